// File: rtl/ifetch_if.sv
// Fetch-side bundle: instruction-memory byte port, decode handshake and execute redirect.
interface ifetch_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_fault;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc,
        output misalign_fault
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc,
        input  misalign_fault
    );
endinterface

// File: rtl/ifetch_sequencer.sv
// Byte-serial instruction fetch: four cycles per little-endian word, held for decode behind valid/ready.
// Optional IFETCH_ALIGN_TRAP_EN: misaligned redirect raises sticky misalign_fault and halts until reset.
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] PC_RESET  = RESET_PC & ADDR_MASK;

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        F2   = 3'd2,
        F3   = 3'd3,
        HOLD = 3'd4
`ifdef IFETCH_ALIGN_TRAP_EN
        , HALT = 3'd5
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [7:0]  r_byte2;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic [31:0] w_mem_addr;
    logic        w_instr_valid;
    logic        w_handshake;
    logic [31:0] w_redir_pc;
    logic        w_redir_take;
    logic        w_misalign;

    // Byte address for the lane being fetched; parked on pc while holding.
    always_comb begin
        w_mem_addr = r_pc;
        case (r_state)
            F1:      w_mem_addr = (r_pc + 32'd1) & ADDR_MASK;
            F2:      w_mem_addr = (r_pc + 32'd2) & ADDR_MASK;
            F3:      w_mem_addr = (r_pc + 32'd3) & ADDR_MASK;
            default: w_mem_addr = r_pc;
        endcase
    end

    assign w_instr_valid = (r_state == HOLD);
    assign w_handshake   = w_instr_valid & bus.instr_ready;
    assign w_redir_pc    = {bus.redirect_pc[31:2], 2'b00} & ADDR_MASK;

`ifdef IFETCH_ALIGN_TRAP_EN
    logic r_fault;
    assign w_redir_take = bus.redirect_valid & (r_state != HALT);
    assign w_misalign   = w_redir_take & (bus.redirect_pc[1:0] != 2'b00);
    assign bus.misalign_fault = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_fault <= 1'b0;
        else if (w_misalign) r_fault <= 1'b1;
    end
`else
    assign w_redir_take = bus.redirect_valid;
    assign w_misalign   = 1'b0;
    assign bus.misalign_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= F0;
            r_pc       <= PC_RESET;
            r_byte0    <= 8'h00;
            r_byte1    <= 8'h00;
            r_byte2    <= 8'h00;
            r_instr    <= 32'h0000_0000;
            r_instr_pc <= PC_RESET;
        end else if (w_redir_take) begin
            // Redirect wins over sequential advance and discards any partial fetch.
`ifdef IFETCH_ALIGN_TRAP_EN
            if (w_misalign) begin
                r_state <= HALT;
            end else begin
                r_pc    <= w_redir_pc;
                r_state <= F0;
            end
`else
            r_pc    <= w_redir_pc;
            r_state <= F0;
`endif
        end else begin
            case (r_state)
                F0: begin
                    r_byte0 <= bus.mem_rdata;
                    r_state <= F1;
                end
                F1: begin
                    r_byte1 <= bus.mem_rdata;
                    r_state <= F2;
                end
                F2: begin
                    r_byte2 <= bus.mem_rdata;
                    r_state <= F3;
                end
                F3: begin
                    r_instr    <= {bus.mem_rdata, r_byte2, r_byte1, r_byte0};
                    r_instr_pc <= r_pc;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (w_handshake) begin
                        r_pc    <= (r_pc + 32'd4) & ADDR_MASK;
                        r_state <= F0;
                    end
                end
`ifdef IFETCH_ALIGN_TRAP_EN
                HALT: r_state <= HALT;
`endif
                default: r_state <= F0;
            endcase
        end
    end

    assign bus.mem_addr    = w_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = w_instr_valid;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: directed test-plan scenarios then random traffic against a transaction-level model.
module tb_ifetch_sequencer;

    localparam int unsigned MEM_BYTES = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem [MEM_BYTES];

    // Model: fetch pc, cycles spent on it (4 = word presented), halt/fault flags.
    int m_pc;
    int m_cnt;
    bit m_halt;
    bit m_fault;

    ifetch_if bus ();

    ifetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int p);
        return {mem[(p + 3) % MEM_BYTES], mem[(p + 2) % MEM_BYTES],
                mem[(p + 1) % MEM_BYTES], mem[p % MEM_BYTES]};
    endfunction

    task automatic put_word(input int p, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[(p + i) % MEM_BYTES] = w[8*i +: 8];
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_instr"}, bus.instr, 32'h0);
        check({tag, "_ipc"}, bus.instr_pc, 32'h0);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_fault"}, 32'(bus.misalign_fault), 32'd0);
    endtask

    task automatic check_model();
        bit vexp;
        int aexp;
        vexp = !m_halt && (m_cnt == 4);
        aexp = (m_halt || m_cnt == 4) ? m_pc : (m_pc + m_cnt) % MEM_BYTES;
        check("valid", 32'(bus.instr_valid), 32'(vexp));
        check("mem_addr", bus.mem_addr, 32'(aexp));
        check("fault", 32'(bus.misalign_fault), 32'(m_fault));
        if (vexp) begin
            check("instr", bus.instr, word_at(m_pc));
            check("instr_pc", bus.instr_pc, 32'(m_pc));
        end
    endtask

    // Drive one edge worth of inputs, advance the model, then check after the edge.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit mis;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
`ifdef IFETCH_ALIGN_TRAP_EN
        mis = (rpc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!m_halt && rv) begin
            if (mis) begin
                m_halt  = 1;
                m_fault = 1;
            end else begin
                m_pc  = int'(rpc & 32'hFFFF_FFFC) % MEM_BYTES;
                m_cnt = 0;
            end
        end else if (!m_halt) begin
            if (m_cnt == 4) begin
                if (rdy) begin
                    m_pc  = (m_pc + 4) % MEM_BYTES;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_instr"}, bus.instr, w);
        check({tag, "_ipc"}, bus.instr_pc, pc);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset(tag);
        model_reset();
        @(negedge clk);
        check_reset({tag, "_held"});
        rst = 1'b0;
    endtask

    initial begin
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
        put_word(32'h00, 32'h8C08_0000);
        put_word(32'h04, 32'h0109_4820);
        put_word(32'h18, 32'h1160_0003);
        model_reset();

        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // Reset vector, then backpressure on the first word.
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("rv0", 32'h8C08_0000, 32'h0);
        repeat (10) step(1'b0, 1'b0, 32'h0);
        expect_word("bp", 32'h8C08_0000, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("bp_next_addr", bus.mem_addr, 32'h4);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        expect_word("rv4", 32'h0109_4820, 32'h4);

        // Redirect in F2 of the next fetch.
        step(1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h18);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        expect_word("mid", 32'h1160_0003, 32'h18);

        // Redirect with handshake in HOLD.
        step(1'b1, 1'b1, 32'h24);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("rdhs", word_at(32'h24), 32'h24);

        // Wrap from the last word.
        step(1'b1, 1'b1, 32'hFC);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("top", word_at(32'hFC), 32'hFC);
        step(1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("wrap", 32'h8C08_0000, 32'h0);

        // Misaligned redirect.
        step(1'b1, 1'b1, 32'h0E);
`ifdef IFETCH_ALIGN_TRAP_EN
        repeat (8) step(1'b1, 1'b1, 32'h20);
        check("trap_fault", 32'(bus.misalign_fault), 32'd1);
        check("trap_valid", 32'(bus.instr_valid), 32'd0);
        async_reset("trap_rst");
`else
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("mis", word_at(32'h0C), 32'h0C);
`endif

        // Reset mid-fetch restarts from the reset vector.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        async_reset("mid_rst");
        repeat (4) step(1'b0, 1'b0, 32'h0);
        expect_word("restart", 32'h8C08_0000, 32'h0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            rpc = 32'($urandom_range(0, MEM_BYTES - 1));
`ifdef IFETCH_ALIGN_TRAP_EN
            if (($urandom % 8) != 0) rpc[1:0] = 2'b00;
`endif
            if (($urandom % 200) == 0) async_reset("rnd_rst");
            else step(($urandom % 4) != 0, ($urandom % 16) == 0, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
